// File: rtl/bin2bcd_div3_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_div3_seq
//
// Sequential binary-to-BCD converter (shift-and-add-3, "double dabble").
// A BIN_W-bit binary value is converted into four BCD digits over BIN_W
// clock cycles. A serial mod-3 remainder is also tracked on the bits as they
// shift out, which yields a divisible-by-3 flag for the converted value.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   start    conversion request, sampled on the rising clk edge while idle
//   bin_in   binary value, captured only on the edge that accepts start
//   busy     high while a conversion is in progress
//   done     one-cycle pulse when the result outputs update
//   dig_a    thousands BCD digit
//   dig_b    hundreds BCD digit
//   dig_c    tens BCD digit
//   dig_d    units BCD digit
//   is_div3  1 when the converted value mod 3 == 0 (and no overflow)
//   ovf      1 when the last captured bin_in exceeded MAX_VAL
// ---------------------------------------------------------------------------
module bin2bcd_div3_seq #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       dig_a,
  output logic [3:0]       dig_b,
  output logic [3:0]       dig_c,
  output logic [3:0]       dig_d,
  output logic             is_div3,
  output logic             ovf
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(MAX_VAL);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state, state_n;
  logic [BIN_W-1:0] bin_reg, bin_reg_n;
  logic [15:0]      scratch, scratch_n;
  logic [1:0]       rem, rem_n;
  logic [CNT_W-1:0] count, count_n;
  logic             ovf_cap, ovf_cap_n;
  logic             done_n, is_div3_n, ovf_n;
  logic [3:0]       dig_a_n, dig_b_n, dig_c_n, dig_d_n;

  logic [15:0]      adj;
  logic [15:0]      scratch_shift;
  logic [BIN_W-1:0] bin_shift;
  logic             msb;
  logic [1:0]       rem_step;

  // Add 3 to a BCD nibble that is 5 or more, so that the following left
  // shift carries correctly into the next decimal digit.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign busy = (state == CONV);

  // State and datapath register; reset aborts any conversion in flight and
  // clears all results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bin_reg <= '0;
      scratch <= '0;
      rem     <= '0;
      count   <= '0;
      ovf_cap <= 1'b0;
      done    <= 1'b0;
      dig_a   <= '0;
      dig_b   <= '0;
      dig_c   <= '0;
      dig_d   <= '0;
      is_div3 <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      bin_reg <= bin_reg_n;
      scratch <= scratch_n;
      rem     <= rem_n;
      count   <= count_n;
      ovf_cap <= ovf_cap_n;
      done    <= done_n;
      dig_a   <= dig_a_n;
      dig_b   <= dig_b_n;
      dig_c   <= dig_c_n;
      dig_d   <= dig_d_n;
      is_div3 <= is_div3_n;
      ovf     <= ovf_n;
    end
  end

  // One shift-and-add-3 step. All four nibbles are adjusted in parallel from
  // their pre-shift values, then {scratch, bin_reg} shifts left one bit. The
  // remainder follows the same bit: r' = (2r + msb) mod 3.
  always_comb begin
    adj = {add3(scratch[15:12]), add3(scratch[11:8]),
           add3(scratch[7:4]), add3(scratch[3:0])};
    msb           = bin_reg[BIN_W-1];
    scratch_shift = 16'({adj, msb});
    bin_shift     = {bin_reg[BIN_W-2:0], 1'b0};
    rem_step      = 2'd0;
    case ({rem, msb})
      3'b000:  rem_step = 2'd0;
      3'b001:  rem_step = 2'd1;
      3'b010:  rem_step = 2'd2;
      3'b011:  rem_step = 2'd0;
      3'b100:  rem_step = 2'd1;
      3'b101:  rem_step = 2'd2;
      default: rem_step = 2'd0;
    endcase
  end

  // Next-state and result logic. Results only change on the completion edge;
  // an overflowing input still runs the full conversion but reports zeros.
  always_comb begin
    state_n   = state;
    bin_reg_n = bin_reg;
    scratch_n = scratch;
    rem_n     = rem;
    count_n   = count;
    ovf_cap_n = ovf_cap;
    done_n    = 1'b0;
    dig_a_n   = dig_a;
    dig_b_n   = dig_b;
    dig_c_n   = dig_c;
    dig_d_n   = dig_d;
    is_div3_n = is_div3;
    ovf_n     = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          bin_reg_n = bin_in;
          scratch_n = '0;
          rem_n     = '0;
          count_n   = '0;
          ovf_cap_n = (bin_in > MAX_BIN);
          state_n   = CONV;
        end
      end
      CONV: begin
        scratch_n = scratch_shift;
        bin_reg_n = bin_shift;
        rem_n     = rem_step;
        count_n   = count + 1'b1;
        if (count == LAST_STEP) begin
          state_n   = IDLE;
          count_n   = '0;
          done_n    = 1'b1;
          dig_a_n   = ovf_cap ? 4'd0 : scratch_shift[15:12];
          dig_b_n   = ovf_cap ? 4'd0 : scratch_shift[11:8];
          dig_c_n   = ovf_cap ? 4'd0 : scratch_shift[7:4];
          dig_d_n   = ovf_cap ? 4'd0 : scratch_shift[3:0];
          is_div3_n = (rem_step == 2'd0) && !ovf_cap;
          ovf_n     = ovf_cap;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bin2bcd_div3_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_div3_seq
//
// Self-checking bench for bin2bcd_div3_seq. Expected digits and flags come
// from plain decimal arithmetic on the requested value; inputs are driven on
// the falling edge and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bin2bcd_div3_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy, done, is_div3, ovf;
  logic [3:0]  dig_a, dig_b, dig_c, dig_d;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  bin2bcd_div3_seq #(.BIN_W(14), .MAX_VAL(9999)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done),
    .dig_a(dig_a), .dig_b(dig_b), .dig_c(dig_c), .dig_d(dig_d),
    .is_div3(is_div3), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // Reference model: decimal digits and divisibility straight from the value.
  task automatic checkOutput(input string tag, input int v);
    bit ov;
    ov = (v > 9999);
    cmp({tag, "_dig_a"}, 32'(dig_a), ov ? 0 : (v / 1000) % 10);
    cmp({tag, "_dig_b"}, 32'(dig_b), ov ? 0 : (v / 100) % 10);
    cmp({tag, "_dig_c"}, 32'(dig_c), ov ? 0 : (v / 10) % 10);
    cmp({tag, "_dig_d"}, 32'(dig_d), ov ? 0 : v % 10);
    cmp({tag, "_is_div3"}, 32'(is_div3), (!ov && (v % 3 == 0)) ? 1 : 0);
    cmp({tag, "_ovf"}, 32'(ovf), ov ? 1 : 0);
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic applyStimulus(input int v);
    start  = 1'b1;
    bin_in = 14'(v);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cycles);
    bit found;
    bit busy_drop;
    found     = 1'b0;
    busy_drop = 1'b0;
    cycles    = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = k;
        found  = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_drop = 1'b1;
    end
    cmp({tag, "_done_seen"}, 32'(found), 1);
    cmp({tag, "_busy_held"}, 32'(busy_drop), 0);
  endtask

  // Full conversion: checks busy, latency, results, pulse width and hold.
  task automatic run_conv(input string tag, input int v, input int prev);
    int cycles;
    applyStimulus(v);
    cmp({tag, "_busy_on"}, 32'(busy), 1);
    repeat (6) @(negedge clk);
    if (prev >= 0) checkOutput({tag, "_hold"}, prev);
    wait_done(tag, cycles);
    cmp({tag, "_latency"}, 6 + cycles, 14);
    cmp({tag, "_busy_off"}, 32'(busy), 0);
    checkOutput(tag, v);
    @(negedge clk);
    cmp({tag, "_done_1cyc"}, 32'(done), 0);
    checkOutput({tag, "_after"}, v);
  endtask

  initial begin
    int cycles;
    int prev;
    int v;
    bit seen;

    // Asynchronous reset: outputs must clear before any clock edge.
    #1 rst = 1'b1;
    #1;
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_done", 32'(done), 0);
    cmp("rst_digs", 32'({dig_a, dig_b, dig_c, dig_d}), 0);
    cmp("rst_div3", 32'(is_div3), 0);
    cmp("rst_ovf", 32'(ovf), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed conversions");
    run_conv("zero", 0, -1);
    run_conv("max", 9999, 0);
    run_conv("v1234", 1234, 9999);
    run_conv("v5001", 5001, 1234);
    run_conv("v10000", 10000, 5001);
    run_conv("v42", 42, 10000);

    // Start while busy is ignored; start in the done cycle is accepted.
    $display("[TB] start while busy / start in done cycle");
    applyStimulus(777);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd3;
    @(negedge clk);
    start  = 1'b0;
    wait_done("v777", cycles);
    cmp("v777_latency", 5 + cycles, 14);
    checkOutput("v777", 777);
    start  = 1'b1;
    bin_in = 14'd81;
    @(negedge clk);
    start  = 1'b0;
    cmp("v81_done_drop", 32'(done), 0);
    cmp("v81_busy_on", 32'(busy), 1);
    checkOutput("v81_hold", 777);
    wait_done("v81", cycles);
    cmp("v81_spacing", 1 + cycles, 15);
    checkOutput("v81", 81);

    // Mid-conversion asynchronous reset aborts with no done pulse.
    $display("[TB] reset during conversion");
    @(negedge clk);
    applyStimulus(500);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("abort_busy", 32'(busy), 0);
    cmp("abort_done", 32'(done), 0);
    cmp("abort_digs", 32'({dig_a, dig_b, dig_c, dig_d}), 0);
    cmp("abort_div3", 32'(is_div3), 0);
    cmp("abort_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    cmp("abort_no_done", 32'(seen), 0);
    cmp("abort_idle", 32'(busy), 0);
    run_conv("v500", 500, -1);

    // Start held high gives conversions every 15 clocks.
    $display("[TB] back-to-back conversions");
    start  = 1'b1;
    bin_in = 14'd6543;
    wait_done("b2b1", cycles);
    cmp("b2b1_latency", cycles, 15);
    checkOutput("b2b1", 6543);
    bin_in = 14'd3210;
    wait_done("b2b2", cycles);
    cmp("b2b2_spacing", cycles, 15);
    checkOutput("b2b2", 3210);
    start = 1'b0;
    @(negedge clk);

    // Randomized values, about a quarter of them out of range.
    $display("[TB] randomized conversions");
    prev = 3210;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10000, 16383));
      else v = int'($urandom_range(0, 9999));
      run_conv($sformatf("rnd%0d", i), v, prev);
      prev = v;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/bin2bcd_div3_seq.md
Name: bin2bcd_div3_seq

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3). Takes a 14-bit binary value (0..9999) and produces four BCD digits, thousands down to units.
- Sits upstream of the 4-digit BCD divisibility-by-3 checker: it generates the digit buses that block consumes, converting in the opposite direction.
- Also computes a serial mod-3 remainder on the binary input. The bench can cross-check this flag against the combinational BCD checker.

Parameters:
- BIN_W, 14, binary input width; also the number of shift cycles per conversion.
- MAX_VAL, 9999, largest convertible input; anything above raises ovf.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request, sampled on rising clk edge.
- bin_in  input  14  binary value; captured only on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the result outputs update.
- dig_a  output  4  thousands BCD digit.
- dig_b  output  4  hundreds BCD digit.
- dig_c  output  4  tens BCD digit.
- dig_d  output  4  units BCD digit.
- is_div3  output  1  1 when the converted value mod 3 == 0.
- ovf  output  1  1 when the last captured bin_in > MAX_VAL.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, dig_a..dig_d=0, is_div3=0, ovf=0, counter=0, remainder=0. Asserting rst mid-conversion aborts immediately: no done pulse, outputs return to zero.
- FSM states: IDLE, CONV.
- IDLE:
  - start=1 at edge E0: latch bin_in into shift register, clear the 16-bit BCD scratch, remainder r=0, count=0, set busy=1, go to CONV.
  - start=0: stay in IDLE.
- CONV, one step per edge, BIN_W steps on edges E1..E14:
  - For each BCD nibble of scratch >= 5, add 3 (all four nibbles checked in parallel, using pre-shift values).
  - Shift {scratch, binreg} left 1 bit. MSB of binreg enters scratch LSB.
  - r <= (2*r + msb) mod 3, where r is 2 bits and msb is the same bit shifted out.
  - count++.
- Completion at edge E14 (count reaches BIN_W-1 before the step):
  - Register final nibbles into dig_a..dig_d.
  - is_div3 = (r_next==0) & ~ovf_cap.
  - ovf = ovf_cap, where ovf_cap = (bin_in > MAX_VAL), evaluated at E0.
  - done=1 for exactly one cycle, busy=0, state -> IDLE.
- Latency: done is high in the cycle after E14, i.e. 14 clocks after the accepting edge. busy is high in the cycles following edges E0..E13.
- Overflow: if ovf_cap=1, the conversion still runs its full 14 cycles. At completion dig_a..dig_d are forced to 0, is_div3=0, ovf=1.
- Outputs hold their values between done pulses. They change only at a completion edge or on reset.
- start while busy=1 is ignored, and bin_in is not re-sampled.
- start=1 in the done cycle is accepted (state is IDLE): the next conversion begins, and done drops the next cycle as usual.
- start held high continuously gives back-to-back conversions, one every 15 clocks.
- Zero input: digits 0,0,0,0 and is_div3=1 (0 is divisible by 3).

Test Plan:
- rst pulse, then start with bin_in=0 -> after 14 clocks done=1 for 1 cycle; digits 0/0/0/0, is_div3=1, ovf=0.
- bin_in=9999 -> digits 9/9/9/9, is_div3=1, ovf=0; busy high for 14 cycles, then low with done.
- bin_in=1234 -> digits 1/2/3/4, is_div3=0. Then bin_in=5001 -> 5/0/0/1, is_div3=1. Outputs hold 1/2/3/4 until the second done.
- bin_in=10000 -> ovf=1, digits 0/0/0/0, is_div3=0. Follow with bin_in=42 -> 0/0/4/2, is_div3=1, ovf=0.
- Start with bin_in=777; pulse start with bin_in=3 at cycle 5 -> pulse ignored; result is 0/7/7/7, is_div3=1. Then start asserted in the done cycle with bin_in=81 -> second done 15 clocks after the first, digits 0/0/8/1.
- Start with bin_in=500; assert rst asynchronously at cycle 7 (between edges) -> busy and outputs go to 0 immediately, no done. Restart with bin_in=500 -> 0/5/0/0, is_div3=0.
